// File: rtl/wb_trace_drain_if.sv
// Bundle between the writeback-stage tap, the commit trace drain and the host read port.
// Read port: a word moves on any rising edge where rd_valid && rd_ready; while rd_valid is high and rd_ready is low, rd_data/rd_last hold.
interface wb_trace_drain_if;
    logic [31:0] wb_pc;
    logic [31:0] wb_ir;
    logic        wb_rf_w;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;

    modport master (
        output wb_pc, wb_ir, wb_rf_w, wb_rd, wb_wdata, rd_ready,
        input  rd_data, rd_valid, rd_last
    );

    modport slave (
        input  wb_pc, wb_ir, wb_rf_w, wb_rd, wb_wdata, rd_ready,
        output rd_data, rd_valid, rd_last
    );
endinterface

// File: rtl/wb_trace_drain.sv
// Writeback commit logger: captures retired instructions into a FIFO and serialises them as 32-bit words.
// Define TRACE_TIMESTAMP_EN to add a free-running cycle stamp as a fifth word per entry.
module wb_trace_drain #(
    parameter int          DEPTH       = 16,
    parameter int          MAX_COMMITS = 1200,
    parameter logic [31:0] BUBBLE_IR   = 32'hffffffff
) (
    input  logic              clk_in,
    input  logic              reset,
    wb_trace_drain_if.slave   bus,
    output logic [15:0]       commit_count,
    output logic              overflow,
    output logic              done,
    output logic [0:0]        dbg_state
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [15:0] MAX_C   = 16'(MAX_COMMITS);
`ifdef TRACE_TIMESTAMP_EN
    localparam logic [2:0]  LAST_IDX = 3'd4;
`else
    localparam logic [2:0]  LAST_IDX = 3'd3;
`endif

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        rf_w;
        logic [4:0]  rd;
        logic [31:0] wdata;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } entry_t;

    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    entry_t      entry_new;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] rd_ptr_inc;
    logic [0:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        rd_last_q, rd_last_d;
    logic [15:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic        done_q, done_d;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
`endif

    logic empty, full, more, qual, push, pop;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_ptr_inc = rd_ptr_q + PTR_ONE;
    assign more       = (rd_ptr_inc != wr_ptr_q);

    function automatic logic [31:0] word_sel(input entry_t e, input logic [2:0] i);
        logic [31:0] w;
        case (i)
            3'd0:    w = e.pc;
            3'd1:    w = e.ir;
            3'd2:    w = {26'b0, e.rf_w, e.rd};
            3'd3:    w = e.rf_w ? e.wdata : 32'd0;
`ifdef TRACE_TIMESTAMP_EN
            3'd4:    w = e.ts;
`endif
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Read side: pop happens only on the transfer of an entry's final word.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d    = S_SEND;
                    idx_d      = 3'd0;
                    rd_valid_d = 1'b1;
                    rd_data_d  = word_sel(mem_q[rd_ptr_q[AW-1:0]], 3'd0);
                    rd_last_d  = 1'b0;
                end
            end
            S_SEND: begin
                if (rd_valid_q && bus.rd_ready) begin
                    if (idx_q == LAST_IDX) begin
                        pop      = 1'b1;
                        rd_ptr_d = rd_ptr_inc;
                        idx_d    = 3'd0;
                        if (more) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = word_sel(mem_q[rd_ptr_inc[AW-1:0]], 3'd0);
                            rd_last_d  = 1'b0;
                        end else begin
                            state_d    = S_IDLE;
                            rd_valid_d = 1'b0;
                            rd_data_d  = 32'd0;
                            rd_last_d  = 1'b0;
                        end
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        rd_data_d = word_sel(mem_q[rd_ptr_q[AW-1:0]], idx_q + 3'd1);
                        rd_last_d = ((idx_q + 3'd1) == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                rd_valid_d = 1'b0;
                rd_data_d  = 32'd0;
                rd_last_d  = 1'b0;
            end
        endcase
    end

    // Capture side: a final-word pop in the same cycle frees the slot a full FIFO needs.
    always_comb begin
        entry_new       = '0;
        entry_new.pc    = bus.wb_pc;
        entry_new.ir    = bus.wb_ir;
        entry_new.rf_w  = bus.wb_rf_w;
        entry_new.rd    = bus.wb_rd;
        entry_new.wdata = bus.wb_wdata;
`ifdef TRACE_TIMESTAMP_EN
        entry_new.ts    = ts_q;
        ts_d            = ts_q + 32'd1;
`endif
        qual       = (bus.wb_ir != BUBBLE_IR) && (count_q < MAX_C);
        push       = qual && (!full || pop);
        wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        count_d    = qual ? (count_q + 16'd1) : count_q;
        overflow_d = overflow_q | (qual && full && !pop);
        done_d     = done_q | ((count_q == MAX_C) && empty && (state_q == S_IDLE));
        mem_d      = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = entry_new;
        end
    end

    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            count_q    <= 16'd0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
            ts_q       <= 32'd0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
`ifdef TRACE_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign commit_count  = count_q;
    assign overflow      = overflow_q;
    assign done          = done_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_wb_trace_drain.sv
// Directed bench for wb_trace_drain: default instance plus a MAX_COMMITS=4 instance sharing the writeback stimulus.
module tb_wb_trace_drain;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        reset;
  logic [31:0] wb_pc, wb_ir, wb_wdata;
  logic        wb_rf_w;
  logic [4:0]  wb_rd;
  logic        rd_ready_a, rd_ready_b;
  logic        sel_b = 1'b0;

  wb_trace_drain_if if_a ();
  wb_trace_drain_if if_b ();

  assign if_a.wb_pc    = wb_pc;
  assign if_a.wb_ir    = wb_ir;
  assign if_a.wb_rf_w  = wb_rf_w;
  assign if_a.wb_rd    = wb_rd;
  assign if_a.wb_wdata = wb_wdata;
  assign if_a.rd_ready = rd_ready_a;
  assign if_b.wb_pc    = wb_pc;
  assign if_b.wb_ir    = wb_ir;
  assign if_b.wb_rf_w  = wb_rf_w;
  assign if_b.wb_rd    = wb_rd;
  assign if_b.wb_wdata = wb_wdata;
  assign if_b.rd_ready = rd_ready_b;

  logic [15:0] cc_a, cc_b;
  logic        ov_a, ov_b, dn_a, dn_b;
  logic [0:0]  st_a, st_b;

  wb_trace_drain u_dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .bus          (if_a),
    .commit_count (cc_a),
    .overflow     (ov_a),
    .done         (dn_a),
    .dbg_state    (st_a)
  );

  wb_trace_drain #(.MAX_COMMITS(4)) u_lim (
    .clk_in       (clk_in),
    .reset        (reset),
    .bus          (if_b),
    .commit_count (cc_b),
    .overflow     (ov_b),
    .done         (dn_b),
    .dbg_state    (st_b)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic logic mon_valid();
    return sel_b ? if_b.rd_valid : if_a.rd_valid;
  endfunction
  function automatic logic [31:0] mon_data();
    return sel_b ? if_b.rd_data : if_a.rd_data;
  endfunction
  function automatic logic mon_last();
    return sel_b ? if_b.rd_last : if_a.rd_last;
  endfunction
  function automatic logic [15:0] mon_count();
    return sel_b ? cc_b : cc_a;
  endfunction
  function automatic logic mon_ovf();
    return sel_b ? ov_b : ov_a;
  endfunction
  function automatic logic mon_done();
    return sel_b ? dn_b : dn_a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_pc = 32'd0; wb_ir = 32'hffffffff; wb_rf_w = 1'b0; wb_rd = 5'd0; wb_wdata = 32'd0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ir, input logic rfw,
                       input logic [4:0] rd, input logic [31:0] wd);
    wb_pc = pc; wb_ir = ir; wb_rf_w = rfw; wb_rd = rd; wb_wdata = wd;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] ir, input logic rfw,
                        input logic [4:0] rd, input logic [31:0] wd);
    drive(pc, ir, rfw, rd, wd);
    @(negedge clk_in);
    idle();
  endtask

  task automatic drive_i(input int i);
    logic [31:0] iv;
    iv = 32'(i);
    drive(32'h00001000 + (iv << 2), 32'h20000000 + iv, iv[0], iv[4:0], 32'ha0000000 + iv);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
  endtask

  // Waits (bounded) for a valid word, checks it, and lets it transfer on the next edge.
  task automatic get_word(input string tag, input logic [31:0] exp, input logic exp_last);
    int k;
    k = 0;
    while (!mon_valid() && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    check({tag, "_valid"}, 32'(mon_valid()), 32'd1);
    check({tag, "_data"}, mon_data(), exp);
    check({tag, "_last"}, 32'(mon_last()), {31'd0, exp_last});
    @(negedge clk_in);
  endtask

  task automatic get_entry(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                           input logic rfw, input logic [4:0] rd, input logic [31:0] wd);
    get_word({tag, "_w0"}, pc, 1'b0);
    get_word({tag, "_w1"}, ir, 1'b0);
    get_word({tag, "_w2"}, {26'd0, rfw, rd}, 1'b0);
    get_word({tag, "_w3"}, rfw ? wd : 32'd0, 1'b1);
  endtask

  task automatic get_entry_i(input string tag, input int i);
    logic [31:0] iv;
    iv = 32'(i);
    get_entry(tag, 32'h00001000 + (iv << 2), 32'h20000000 + iv, iv[0], iv[4:0], 32'ha0000000 + iv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    rd_ready_a = 1'b1;
    rd_ready_b = 1'b0;
    repeat (3) @(negedge clk_in);
    reset = 1'b1;

    // Reset state
    check("rst_valid", 32'(if_a.rd_valid), 32'd0);
    check("rst_data",  if_a.rd_data, 32'd0);
    check("rst_last",  32'(if_a.rd_last), 32'd0);
    check("rst_count", 32'(cc_a), 32'd0);
    check("rst_ovf",   32'(ov_a), 32'd0);
    check("rst_done",  32'(dn_a), 32'd0);

    // Bubbles never capture
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      check("bubble_valid", 32'(if_a.rd_valid), 32'd0);
    end
    check("bubble_count", 32'(cc_a), 32'd0);

    // Single commit, one cycle latency
    commit(32'h00400000, 32'h24010005, 1'b1, 5'd1, 32'd5);
    check("lat_valid0", 32'(if_a.rd_valid), 32'd0);
    @(negedge clk_in);
    check("lat_valid1", 32'(if_a.rd_valid), 32'd1);
    get_word("single_w0", 32'h00400000, 1'b0);
    get_word("single_w1", 32'h24010005, 1'b0);
    get_word("single_w2", 32'h00000021, 1'b0);
    get_word("single_w3", 32'h00000005, 1'b1);
    check("single_count", 32'(cc_a), 32'd1);
    check("single_idle", 32'(if_a.rd_valid), 32'd0);

    // Backpressure mid-entry
    commit(32'h00400004, 32'h00221020, 1'b1, 5'd2, 32'h0000000a);
    get_word("bp_w0", 32'h00400004, 1'b0);
    rd_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(if_a.rd_valid), 32'd1);
      check("bp_hold_data", if_a.rd_data, 32'h00221020);
      check("bp_hold_last", 32'(if_a.rd_last), 32'd0);
      @(negedge clk_in);
    end
    rd_ready_a = 1'b1;
    get_word("bp_w1", 32'h00221020, 1'b0);
    get_word("bp_w2", 32'h00000022, 1'b0);
    get_word("bp_w3", 32'h0000000a, 1'b1);

    // No register write: word 3 reads as zero
    commit(32'h00400008, 32'hac010000, 1'b0, 5'd0, 32'h12345678);
    get_entry("nowr", 32'h00400008, 32'hac010000, 1'b0, 5'd0, 32'h12345678);
    check("nowr_count", 32'(cc_a), 32'd3);

    // Fill to full, then push in the same cycle as a final-word pop
    do_reset();
    rd_ready_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_i(i);
      @(negedge clk_in);
    end
    idle();
    @(negedge clk_in);
    check("full_ovf", 32'(ov_a), 32'd0);
    check("full_count", 32'(cc_a), 32'd16);
    rd_ready_a = 1'b1;
    get_word("sim_e0_w0", 32'h00001000, 1'b0);
    get_word("sim_e0_w1", 32'h20000000, 1'b0);
    get_word("sim_e0_w2", 32'h00000000, 1'b0);
    check("sim_e0_w3_data", if_a.rd_data, 32'h00000000);
    check("sim_e0_w3_last", 32'(if_a.rd_last), 32'd1);
    drive_i(16);
    @(negedge clk_in);
    idle();
    for (int i = 1; i <= 16; i++) get_entry_i("sim", i);
    check("sim_ovf", 32'(ov_a), 32'd0);
    check("sim_count", 32'(cc_a), 32'd17);

    // Overflow: DEPTH+2 commits with the host stalled
    do_reset();
    rd_ready_a = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive_i(i);
      @(negedge clk_in);
    end
    idle();
    @(negedge clk_in);
    check("ovf_flag", 32'(ov_a), 32'd1);
    check("ovf_count", 32'(cc_a), 32'd18);
    rd_ready_a = 1'b1;
    for (int i = 0; i < 16; i++) get_entry_i("ovf", i);
    repeat (2) @(negedge clk_in);
    check("ovf_drained", 32'(if_a.rd_valid), 32'd0);
    check("ovf_sticky", 32'(ov_a), 32'd1);

    // Reset in the middle of an entry
    commit(32'h00400010, 32'h24030007, 1'b1, 5'd3, 32'd7);
    get_word("mid_w0", 32'h00400010, 1'b0);
    get_word("mid_w1", 32'h24030007, 1'b0);
    reset = 1'b0;
    @(negedge clk_in);
    check("mid_rst_valid", 32'(if_a.rd_valid), 32'd0);
    check("mid_rst_data", if_a.rd_data, 32'd0);
    check("mid_rst_count", 32'(cc_a), 32'd0);
    check("mid_rst_ovf", 32'(ov_a), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    check("mid_quiet", 32'(if_a.rd_valid), 32'd0);
    commit(32'h00400014, 32'h24040009, 1'b1, 5'd4, 32'd9);
    get_entry("mid_next", 32'h00400014, 32'h24040009, 1'b1, 5'd4, 32'd9);
    check("mid_next_count", 32'(cc_a), 32'd1);

    // Commit limit on the MAX_COMMITS=4 instance
    do_reset();
    sel_b = 1'b1;
    rd_ready_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_i(i);
      @(negedge clk_in);
    end
    idle();
    @(negedge clk_in);
    check("lim_count", 32'(mon_count()), 32'd4);
    check("lim_ovf", 32'(mon_ovf()), 32'd0);
    check("lim_done_early", 32'(mon_done()), 32'd0);
    rd_ready_b = 1'b1;
    for (int i = 0; i < 4; i++) get_entry_i("lim", i);
    @(negedge clk_in);
    check("lim_done", 32'(mon_done()), 32'd1);
    check("lim_empty", 32'(mon_valid()), 32'd0);
    commit(32'h00400100, 32'h24050001, 1'b1, 5'd5, 32'd1);
    repeat (3) @(negedge clk_in);
    check("lim_after_count", 32'(mon_count()), 32'd4);
    check("lim_after_valid", 32'(mon_valid()), 32'd0);
    check("lim_after_done", 32'(mon_done()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_trace_drain.md
Name: wb_trace_drain

Overview:
- Hardware counterpart of the pipeline's writeback-stage commit logger.
- Captures each retired instruction from the MEM/WB boundary of the 5-stage CPU: pc, instruction, register-write info and write data.
- Buffers commits in a FIFO and serialises them as 32-bit words over a valid/ready read port, so a host or debug UART can drain the commit stream.
- Sits beside sccomp_dataflow and taps pc4/IR4/me_wb_RF_W/rdcmux_out/rdmux_out-equivalent signals.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, >=2).
- MAX_COMMITS, 1200, commits captured after reset; later commits are ignored.
- BUBBLE_IR, 32'hffffffff, instruction encoding that marks a pipeline bubble.

Ports:
- clk_in  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- wb_pc  in  32  pc of instruction in WB.
- wb_ir  in  32  instruction in WB.
- wb_rf_w  in  1  register-file write enable in WB.
- wb_rd  in  5  destination register in WB.
- wb_wdata  in  32  register write data in WB.
- rd_data  out  32  current output word.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  host accepts word.
- rd_last  out  1  current word is the final word of its entry.
- commit_count  out  16  commits captured since reset, saturating at MAX_COMMITS.
- overflow  out  1  sticky; a commit was dropped because the FIFO was full.
- done  out  1  commit_count==MAX_COMMITS and FIFO empty and no entry in flight.

Behaviour:
- Reset (reset==0 at a rising edge) clears all of the following: FIFO pointers, word index, commit_count, overflow, rd_valid, rd_last, done, and drives rd_data to 0. Reset mid-drain abandons the partial entry and no further words are emitted.
- Capture qualifier, evaluated every cycle: wb_ir!=BUBBLE_IR and commit_count<MAX_COMMITS.
- When the qualifier holds and the FIFO is not full:
  - push {wb_pc, wb_ir, wb_rf_w, wb_rd, wb_wdata};
  - commit_count+1.
- When the qualifier holds and the FIFO is full:
  - entry dropped;
  - overflow<=1;
  - commit_count still +1, so it counts retirements, not stored entries.
- FIFO full/empty use an extra wrap bit on each pointer. Pointers wrap modulo DEPTH.
- Read FSM:
  - IDLE: FIFO empty → rd_valid=0. Non-empty → go to SEND with word index 0.
  - SEND: rd_valid=1. rd_data selects by index:
    - 0 → pc
    - 1 → ir
    - 2 → {26'b0, rf_w, rd}
    - 3 → wdata (0 when rf_w==0)
  - rd_last=1 on the final index.
  - A word transfers on rd_valid&&rd_ready. Non-final word: index+1. Final word: pop the entry and index<=0; stay in SEND if another entry exists, else go to IDLE.
  - rd_data and rd_valid are registered and hold stable while rd_valid&&!rd_ready.
- Latency: a commit at edge N produces its first word with rd_valid high after edge N+1 when the FIFO was empty, so 1 cycle.
- Simultaneous push and final-word pop with the FIFO full: the pop frees a slot in the same cycle, so the push succeeds and overflow is not set.
- done asserts combinationally-registered one cycle after the conditions hold. It stays high until reset.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - a free-running 32-bit cycle counter (cleared by reset, wraps at 2^32) is stored with each entry;
  - each entry has 5 words, and word 4 = timestamp;
  - rd_last moves to index 4.
- Undefined: no counter is built, and entries have 4 words as above.

Test Plan:
- Single commit: pc=0x00400000, ir=0x24010005, rf_w=1, rd=1, wdata=5, rd_ready=1 → words 0x00400000, 0x24010005, 0x00000021, 0x00000005; rd_last only on the 4th word; commit_count=1.
- Bubbles: 10 cycles of wb_ir=0xffffffff → no rd_valid, commit_count=0.
- Backpressure: rd_ready=0 for 5 cycles mid-entry → rd_data/rd_valid held stable; words resume in order after rd_ready=1.
- Overflow: rd_ready=0, DEPTH+2 commits → overflow=1 and commit_count=DEPTH+2. Draining yields exactly DEPTH entries, which are the first DEPTH commits.
- Limit: MAX_COMMITS=4, 6 commits, drain all → 4 entries, commit_count=4, done=1 after the last rd_last transfer.
- Reset mid-entry: reset=0 after word 1 → rd_valid=0, commit_count=0, overflow=0; the next commit starts cleanly at word 0.
